// File: rtl/conv_window_feeder.sv
// Feeds fp16 windows and per-tap weights from local tile/kernel buffers to the
// convolution core for kernel_size^2 beats, then captures the core's result.
//
// state | meaning
// IDLE  | buffers writable, waiting for start; core held in reset
// FEED  | one window + weight per cycle for taps (0,0)..(K-1,K-1)
// WAIT  | last window held, weight 0, waiting for result_ready
// DONE  | out_valid pulse, core reset asserted
module conv_window_feeder #(
    parameter int DATA_WIDTH        = 16,
    parameter int PARA_X            = 3,
    parameter int PARA_Y            = 3,
    parameter int KERNEL_SIZE_MAX   = 11,
    parameter int KERNEL_SIZE_WIDTH = 6,
    parameter int TILE_ADDR_WIDTH   = 8,
    parameter int WEIGHT_ADDR_WIDTH = 7
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 tile_we_i,
    input  logic [TILE_ADDR_WIDTH-1:0]           tile_addr_i,
    input  logic [DATA_WIDTH-1:0]                tile_wdata_i,
    input  logic                                 wgt_we_i,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]         wgt_addr_i,
    input  logic [DATA_WIDTH-1:0]                wgt_wdata_i,
    input  logic                                 start_i,
    input  logic [KERNEL_SIZE_WIDTH-1:0]         kernel_size_in_i,
    output logic                                 busy_o,
    output logic                                 err_o,
    output logic                                 conv_rst_o,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  conv_input_data_o,
    output logic [DATA_WIDTH-1:0]                conv_weight_o,
    output logic [KERNEL_SIZE_WIDTH-1:0]         conv_kernel_size_o,
    input  logic                                 conv_result_ready_i,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  conv_result_buffer_i,
    output logic                                 out_valid_o,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  out_data_o
);

    localparam int TILE_DIM   = PARA_X + KERNEL_SIZE_MAX - 1;
    localparam int TILE_DEPTH = TILE_DIM * TILE_DIM;
    localparam int WGT_DEPTH  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int WIN_W      = PARA_X * PARA_Y * DATA_WIDTH;

    localparam logic [TILE_ADDR_WIDTH-1:0]   TILE_LAST = TILE_ADDR_WIDTH'(TILE_DEPTH - 1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] WGT_LAST  = WEIGHT_ADDR_WIDTH'(WGT_DEPTH - 1);
    localparam logic [KERNEL_SIZE_WIDTH-1:0] K_MAX     = KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [KERNEL_SIZE_WIDTH-1:0]   ksize_q, ksize_d;
    logic [KERNEL_SIZE_WIDTH-1:0]   ky_q, ky_d, kx_q, kx_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   tap_q, tap_d;
    logic                           busy_q, busy_d;
    logic                           err_q, err_d;
    logic                           out_valid_q, out_valid_d;
    logic                           conv_rst_q, conv_rst_d;
    logic [WIN_W-1:0]               win_q, win_d;
    logic [DATA_WIDTH-1:0]          wgt_out_q, wgt_out_d;
    logic [WIN_W-1:0]               out_data_q, out_data_d;
    logic                           load_beat;

    logic [DATA_WIDTH-1:0]          tile_mem [TILE_DEPTH];
    logic [DATA_WIDTH-1:0]          wgt_mem  [WGT_DEPTH];

    logic                           tile_fwd, wgt_fwd, k_ok;

    // Writes only land while idle; a write coinciding with start is forwarded
    // so the first beat already sees it.
    assign tile_fwd = (state_q == S_IDLE) && tile_we_i;
    assign wgt_fwd  = (state_q == S_IDLE) && wgt_we_i;
    assign k_ok     = (kernel_size_in_i != '0) && (kernel_size_in_i <= K_MAX);

    always_ff @(posedge clk_i) begin
        if (tile_fwd && (tile_addr_i <= TILE_LAST)) begin
            tile_mem[tile_addr_i] <= tile_wdata_i;
        end
        if (wgt_fwd && (wgt_addr_i <= WGT_LAST)) begin
            wgt_mem[wgt_addr_i] <= wgt_wdata_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        ksize_d     = ksize_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        tap_d       = tap_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        out_valid_d = 1'b0;
        conv_rst_d  = conv_rst_q;
        out_data_d  = out_data_q;
        load_beat   = 1'b0;
        case (state_q)
            S_IDLE: begin
                conv_rst_d = 1'b0;
                busy_d     = 1'b0;
                // busy_q still high here means this is the cycle right after DONE
                if (start_i && !busy_q) begin
                    if (k_ok) begin
                        state_d    = S_FEED;
                        ksize_d    = kernel_size_in_i;
                        ky_d       = '0;
                        kx_d       = '0;
                        tap_d      = '0;
                        busy_d     = 1'b1;
                        conv_rst_d = 1'b1;
                        load_beat  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FEED: begin
                if (kx_q == ksize_q - 1'b1) begin
                    if (ky_q == ksize_q - 1'b1) begin
                        state_d = S_WAIT;
                    end else begin
                        kx_d      = '0;
                        ky_d      = ky_q + 1'b1;
                        tap_d     = tap_q + 1'b1;
                        load_beat = 1'b1;
                    end
                end else begin
                    kx_d      = kx_q + 1'b1;
                    tap_d     = tap_q + 1'b1;
                    load_beat = 1'b1;
                end
            end
            S_WAIT: begin
                if (conv_result_ready_i) begin
                    state_d     = S_DONE;
                    out_data_d  = conv_result_buffer_i;
                    out_valid_d = 1'b1;
                    conv_rst_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                conv_rst_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : win_build
        logic [TILE_ADDR_WIDTH-1:0] pa;
        win_d = win_q;
        pa    = '0;
        if (load_beat) begin
            for (int i = 0; i < PARA_Y; i++) begin
                for (int j = 0; j < PARA_X; j++) begin
                    pa = TILE_ADDR_WIDTH'((i + int'(ky_d)) * TILE_DIM + j + int'(kx_d));
                    win_d[(i*PARA_X+j)*DATA_WIDTH +: DATA_WIDTH] =
                        (tile_fwd && (pa == tile_addr_i)) ? tile_wdata_i : tile_mem[pa];
                end
            end
        end
    end

    always_comb begin
        wgt_out_d = '0;
        if (load_beat) begin
            wgt_out_d = (wgt_fwd && (wgt_addr_i == tap_d)) ? wgt_wdata_i : wgt_mem[tap_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            ksize_q     <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            tap_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            conv_rst_q  <= 1'b0;
            win_q       <= '0;
            wgt_out_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ksize_q     <= ksize_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            tap_q       <= tap_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            conv_rst_q  <= conv_rst_d;
            win_q       <= win_d;
            wgt_out_q   <= wgt_out_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy_o             = busy_q;
    assign err_o              = err_q;
    assign out_valid_o        = out_valid_q;
    assign conv_rst_o         = conv_rst_q;
    assign conv_input_data_o  = win_q;
    assign conv_weight_o      = wgt_out_q;
    assign conv_kernel_size_o = ksize_q;
    assign out_data_o         = out_data_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: buffer model, beat/result scoreboard and a
// behavioural stand-in for the convolution core's result handshake.
module tb_conv_window_feeder;

    localparam int DW    = 16;
    localparam int PX    = 3;
    localparam int PY    = 3;
    localparam int KMAX  = 11;
    localparam int KSW   = 6;
    localparam int TAW   = 8;
    localparam int WAW   = 7;
    localparam int TDIM  = PX + KMAX - 1;
    localparam int WIN_W = PX * PY * DW;

    typedef logic [WIN_W-1:0] wide_t;

    typedef struct {
        int          k;
        int          delay;
        logic [15:0] res_base;
        logic [15:0] res_step;
        bit          wload;
        bit          fwd;
        logic [15:0] fwd_val;
    } vec_t;

    typedef struct {
        wide_t       win;
        logic [15:0] wgt;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tile_we = 1'b0;
    logic [TAW-1:0]   tile_addr = '0;
    logic [DW-1:0]    tile_wdata = '0;
    logic             wgt_we = 1'b0;
    logic [WAW-1:0]   wgt_addr = '0;
    logic [DW-1:0]    wgt_wdata = '0;
    logic             start = 1'b0;
    logic [KSW-1:0]   kernel_size_in = '0;
    logic             busy, err, conv_rst, out_valid;
    wide_t            conv_input_data, out_data;
    logic [DW-1:0]    conv_weight;
    logic [KSW-1:0]   conv_kernel_size;
    logic             conv_result_ready = 1'b0;
    wide_t            conv_result_buffer = '0;

    logic [15:0] tile_m [TDIM*TDIM];
    logic [15:0] wgt_m  [KMAX*KMAX];
    beat_t       beat_q[$];
    wide_t       res_q[$];
    vec_t        vecs[9];

    int n_chk  = 0;
    int n_fail = 0;

    conv_window_feeder dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .tile_we_i            (tile_we),
        .tile_addr_i          (tile_addr),
        .tile_wdata_i         (tile_wdata),
        .wgt_we_i             (wgt_we),
        .wgt_addr_i           (wgt_addr),
        .wgt_wdata_i          (wgt_wdata),
        .start_i              (start),
        .kernel_size_in_i     (kernel_size_in),
        .busy_o               (busy),
        .err_o                (err),
        .conv_rst_o           (conv_rst),
        .conv_input_data_o    (conv_input_data),
        .conv_weight_o        (conv_weight),
        .conv_kernel_size_o   (conv_kernel_size),
        .conv_result_ready_i  (conv_result_ready),
        .conv_result_buffer_i (conv_result_buffer),
        .out_valid_o          (out_valid),
        .out_data_o           (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] fp16(input int n);
        int          e;
        logic [15:0] r;
        if (n == 0) return 16'h0000;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        r        = '0;
        r[14:10] = 5'(e + 15);
        r[9:0]   = 10'((n << (10 - e)) & 'h3ff);
        return r;
    endfunction

    task automatic wr_tile(input int a, input logic [15:0] d);
        @(negedge clk);
        tile_we = 1'b1; tile_addr = TAW'(a); tile_wdata = d;
        tile_m[a] = d;
        @(negedge clk);
        tile_we = 1'b0;
    endtask

    task automatic wr_wgt(input int a, input logic [15:0] d);
        @(negedge clk);
        wgt_we = 1'b1; wgt_addr = WAW'(a); wgt_wdata = d;
        wgt_m[a] = d;
        @(negedge clk);
        wgt_we = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " busy"}, wide_t'(busy), '0);
        chk({tag, " err"}, wide_t'(err), '0);
        chk({tag, " out_valid"}, wide_t'(out_valid), '0);
        chk({tag, " conv_rst"}, wide_t'(conv_rst), '0);
        chk({tag, " conv_input_data"}, conv_input_data, '0);
        chk({tag, " conv_weight"}, wide_t'(conv_weight), '0);
        chk({tag, " conv_kernel_size"}, wide_t'(conv_kernel_size), '0);
        chk({tag, " out_data"}, out_data, '0);
    endtask

    task automatic run_vec(input vec_t v);
        beat_t b;
        wide_t last_win, res, exp_res;
        bit    acc;
        acc = (v.k >= 1) && (v.k <= KMAX);
        last_win = '0;
        if (v.wload) begin
            for (int t = 0; t < KMAX*KMAX; t++) wr_wgt(t, fp16(t));
        end
        @(negedge clk);
        start = 1'b1;
        kernel_size_in = KSW'(v.k);
        if (v.fwd) begin
            tile_we = 1'b1; tile_addr = '0; tile_wdata = v.fwd_val;
            tile_m[0] = v.fwd_val;
        end
        if (acc) begin
            for (int ky = 0; ky < v.k; ky++) begin
                for (int kx = 0; kx < v.k; kx++) begin
                    for (int i = 0; i < PY; i++)
                        for (int j = 0; j < PX; j++)
                            b.win[(i*PX+j)*DW +: DW] = tile_m[(i+ky)*TDIM + j + kx];
                    b.wgt = wgt_m[ky*v.k + kx];
                    beat_q.push_back(b);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        tile_we = 1'b0;
        if (!acc) begin
            chk("reject err pulse", wide_t'(err), wide_t'(1));
            chk("reject busy", wide_t'(busy), '0);
            chk("reject conv_rst", wide_t'(conv_rst), '0);
            @(negedge clk);
            chk("reject err one cycle", wide_t'(err), '0);
            chk("reject stays idle", wide_t'(conv_rst), '0);
            return;
        end
        chk("busy after start", wide_t'(busy), wide_t'(1));
        for (int t = 0; t < v.k * v.k; t++) begin
            if (t > 0) @(negedge clk);
            if (beat_q.size() == 0) begin
                chk("beat queue underflow", wide_t'(1), '0);
            end else begin
                b = beat_q.pop_front();
                chk($sformatf("K%0d beat %0d window", v.k, t), conv_input_data, b.win);
                chk($sformatf("K%0d beat %0d weight", v.k, t), wide_t'(conv_weight), wide_t'(b.wgt));
                chk($sformatf("K%0d beat %0d conv_rst", v.k, t), wide_t'(conv_rst), wide_t'(1));
                chk($sformatf("K%0d beat %0d ksize", v.k, t), wide_t'(conv_kernel_size), wide_t'(v.k));
                chk($sformatf("K%0d beat %0d err", v.k, t), wide_t'(err), '0);
                last_win = b.win;
            end
            // writes and a bad start while busy must have no effect
            tile_we = 1'b1; tile_addr = TAW'(t); tile_wdata = 16'hdead;
            wgt_we = 1'b1; wgt_addr = WAW'(t); wgt_wdata = 16'hbeef;
            start = (t == 0); kernel_size_in = '0;
        end
        @(negedge clk);
        start = 1'b0;
        chk("wait weight zero", wide_t'(conv_weight), '0);
        chk("wait window held", conv_input_data, last_win);
        chk("wait conv_rst", wide_t'(conv_rst), wide_t'(1));
        chk("wait no out_valid", wide_t'(out_valid), '0);
        chk("busy start ignored no err", wide_t'(err), '0);
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            chk($sformatf("wait hold %0d conv_rst", d), wide_t'(conv_rst), wide_t'(1));
            chk($sformatf("wait hold %0d out_valid", d), wide_t'(out_valid), '0);
        end
        for (int e = 0; e < PX*PY; e++) res[e*DW +: DW] = v.res_base + 16'(e) * v.res_step;
        conv_result_ready = 1'b1;
        conv_result_buffer = res;
        res_q.push_back(res);
        tile_we = 1'b0; wgt_we = 1'b0;
        @(negedge clk);
        conv_result_ready = 1'b0;
        conv_result_buffer = ~res;
        chk("out_valid after ready", wide_t'(out_valid), wide_t'(1));
        exp_res = (res_q.size() != 0) ? res_q.pop_front() : '0;
        chk("out_data capture", out_data, exp_res);
        chk("done conv_rst low", wide_t'(conv_rst), '0);
        chk("done busy", wide_t'(busy), wide_t'(1));
        @(negedge clk);
        chk("out_valid single pulse", wide_t'(out_valid), '0);
        chk("busy done+1", wide_t'(busy), wide_t'(1));
        chk("out_data held", out_data, exp_res);
        start = 1'b1; kernel_size_in = KSW'(2);
        @(negedge clk);
        start = 1'b0;
        chk("busy falls", wide_t'(busy), '0);
        chk("idle conv_rst", wide_t'(conv_rst), '0);
        chk("start at done+1 no err", wide_t'(err), '0);
        @(negedge clk);
        chk("start at done+1 ignored", wide_t'(conv_rst), '0);
    endtask

    initial begin
        vecs[0] = '{k: 3,  delay: 2,  res_base: 16'h1000, res_step: 16'h0011, wload: 0, fwd: 0, fwd_val: 16'h0};
        vecs[1] = '{k: 1,  delay: 0,  res_base: 16'h2000, res_step: 16'h0101, wload: 0, fwd: 0, fwd_val: 16'h0};
        vecs[2] = '{k: 0,  delay: 0,  res_base: 16'h0,    res_step: 16'h0,    wload: 0, fwd: 0, fwd_val: 16'h0};
        vecs[3] = '{k: 12, delay: 0,  res_base: 16'h0,    res_step: 16'h0,    wload: 0, fwd: 0, fwd_val: 16'h0};
        vecs[4] = '{k: 5,  delay: 3,  res_base: 16'h3000, res_step: 16'h0001, wload: 1, fwd: 0, fwd_val: 16'h0};
        vecs[5] = '{k: 3,  delay: 20, res_base: 16'h4400, res_step: 16'h0000, wload: 0, fwd: 0, fwd_val: 16'h0};
        vecs[6] = '{k: 1,  delay: 1,  res_base: 16'h5000, res_step: 16'h0003, wload: 0, fwd: 1, fwd_val: 16'h5a5a};
        vecs[7] = '{k: 11, delay: 0,  res_base: 16'h6000, res_step: 16'h0202, wload: 0, fwd: 0, fwd_val: 16'h0};
        vecs[8] = '{k: 2,  delay: 0,  res_base: 16'h7000, res_step: 16'h0001, wload: 0, fwd: 0, fwd_val: 16'h0};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;

        for (int r = 0; r < TDIM; r++)
            for (int c = 0; c < TDIM; c++) wr_tile(r*TDIM + c, fp16(r + c));
        for (int t = 0; t < KMAX*KMAX; t++) wr_wgt(t, 16'h3c00);

        for (int n = 0; n < 9; n++) run_vec(vecs[n]);

        // reset in the middle of a K=3 run, then a clean replay
        @(negedge clk);
        start = 1'b1; kernel_size_in = KSW'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("beat 4 before reset weight", wide_t'(conv_weight), wide_t'(wgt_m[4]));
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrun reset");
        rst = 1'b1;
        @(negedge clk);
        chk("after reset idle conv_rst", wide_t'(conv_rst), '0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Drives the input side of `ConvParaScaleFloat16` and collects its result: it holds one input tile and one kernel's weights, then sequences kernel_size² beats. Each beat presents a full PARA_X×PARA_Y window of fp16 pixels plus one fp16 weight. When the convolution core raises `result_ready`, the block captures `result_buffer` and hands it downstream. It sits between the feature-map/weight buffers and the convolution core, and replaces the hand-written stimulus currently used to exercise that core.

## Interface
- DATA_WIDTH, 16, fp16 word width
- PARA_X, 3, output columns per tile (MAC groups)
- PARA_Y, 3, output rows per tile (MACs per group)
- KERNEL_SIZE_MAX, 11, largest supported kernel
- KERNEL_SIZE_WIDTH, 6, kernel_size field width
- TILE_DIM, PARA_X+KERNEL_SIZE_MAX-1, tile edge in words (square tile; requires PARA_X==PARA_Y)
- TILE_ADDR_WIDTH, 8, covers TILE_DIM² entries
- WEIGHT_ADDR_WIDTH, 7, covers KERNEL_SIZE_MAX² entries

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-low reset (0: reset; 1: run)
- tile_we  in  1  tile buffer write strobe
- tile_addr  in  TILE_ADDR_WIDTH  row*TILE_DIM+col
- tile_wdata  in  DATA_WIDTH  pixel
- wgt_we  in  1  weight buffer write strobe
- wgt_addr  in  WEIGHT_ADDR_WIDTH  tap index ky*kernel_size+kx
- wgt_wdata  in  DATA_WIDTH  weight
- start  in  1  one-cycle request to run
- kernel_size_in  in  KERNEL_SIZE_WIDTH  kernel for this run
- busy  out  1  high from accepted start until the cycle after out_valid
- err  out  1  one-cycle pulse on rejected start
- conv_rst  out  1  active-low reset to the core
- conv_input_data  out  PARA_X*PARA_Y*DATA_WIDTH  window
- conv_weight  out  DATA_WIDTH  tap weight
- conv_kernel_size  out  KERNEL_SIZE_WIDTH  latched kernel size
- conv_result_ready  in  1  from core
- conv_result_buffer  in  PARA_X*PARA_Y*DATA_WIDTH  from core
- out_valid  out  1  one-cycle pulse; out_data valid
- out_data  out  PARA_X*PARA_Y*DATA_WIDTH  captured result, held until next capture

## Operation
- States: IDLE, FEED, WAIT, DONE.
- IDLE
  - conv_rst=0.
  - Buffer writes accepted only in IDLE; writes in any other state are ignored.
  - start with 1≤kernel_size_in≤KERNEL_SIZE_MAX: latch K, set tap counters ky=kx=0, go to FEED.
  - start with K=0 or K>KERNEL_SIZE_MAX: pulse err, stay in IDLE.
  - If start and a buffer write arrive in the same cycle, the write lands first and is visible to the run.
- FEED, one beat per cycle
  - conv_rst=1.
  - conv_weight = wgt[ky*K+kx].
  - Window element e = i*PARA_X+j (i = row 0..PARA_Y-1, j = col 0..PARA_X-1) occupies conv_input_data[e*DATA_WIDTH +: DATA_WIDTH] and equals tile[(i+ky)*TILE_DIM + (j+kx)].
  - kx increments and wraps at K-1; ky increments on that wrap.
  - After beat (K-1,K-1), go to WAIT.
- WAIT
  - conv_rst=1; conv_weight=0; conv_input_data holds the last window.
  - On conv_result_ready=1: out_data ← conv_result_buffer, go to DONE.
  - No timeout.
- DONE (one cycle)
  - out_valid=1, conv_rst=0 (clears the core), go to IDLE.
- conv_kernel_size always equals the latched K.
- No arithmetic on data; the block only moves data. Tap index arithmetic is held at WEIGHT_ADDR_WIDTH bits.

## Timing
- Outputs are registered. The beat for tap t appears on the outputs in cycle s+1+t, where s is the start cycle.
- Last beat: cycle s+K². WAIT begins at cycle s+K²+1.
- out_valid is asserted the cycle after conv_result_ready is sampled high.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- Reset values (rst=0, any state, mid-run included):
  - state=IDLE
  - busy, err, out_valid, conv_rst = 0
  - conv_input_data, conv_weight, conv_kernel_size, out_data = 0
  - counters = 0
  - Buffer contents are not cleared.
- start while busy is ignored and does not pulse err.

## Test plan
- Load tile[r][c]=fp16(r+c) and all weights 3c00, start with K=3 → exactly 9 FEED beats. Beat 0 window element 0 = 0000 (fp16 0); beat 8 element 8 = tile[4][4] = 4800 (fp16 8). conv_rst high for beats 0-8.
- K=1 → 1 beat, window = tile rows 0-2 × cols 0-2. Core result from the real ConvParaScaleFloat16 matches tile×weight.
- K=5 with the real core, weights = tap index in fp16 → out_data equals a golden model. out_valid pulses exactly once; busy spans s+1 through DONE+1.
- start with K=0, then with K=12 → err pulses each time, busy stays 0, conv_rst stays 0.
- Drive rst=0 at beat 4 of a K=3 run → next cycle all outputs 0 and state IDLE. A fresh start with K=3 replays from tap 0, using the unchanged buffers.
- Hold conv_result_ready low for 20 cycles after the last beat → WAIT is held with conv_rst=1 and no out_valid. Raise it with result 4400 in every lane → out_data lanes all 4400, one-cycle out_valid.
